// File: rtl/tx_rs232.sv
//==============================================================================
// Module      : tx_rs232
// Description : RS232 UART transmitter. Serialises one byte per accepted
//               request into an 11-bit frame (start, D0..D7 LSB first,
//               parity slot, stop), followed by IDLE_BITS guard bit-times
//               of mark before the next start bit can be driven.
//               Optional macro TX_PARITY_EN: when defined the parity slot
//               carries even parity of the byte; otherwise it is mark (1).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tx_rs232 #(
  parameter int CLK_PER_BIT = 5208,
  parameter int IDLE_BITS   = 1
) (
  input  logic       clk_s,
  input  logic       rstn_s,
  input  logic [7:0] iDATA,
  input  logic       iSTART,
  output logic       oTX,
  output logic       oBUSY,
  output logic       oDONE
);

  // Bit-time counter sizing; a one-clock bit still needs a 1-bit counter.
  localparam int c_cnt_w = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [c_cnt_w-1:0] c_bit_last = c_cnt_w'(CLK_PER_BIT - 1);
  // Index of the last guard bit; unused when the guard is disabled.
  localparam logic [2:0] c_gap_last = (IDLE_BITS > 0) ? 3'(IDLE_BITS - 1) : 3'd0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_clk_cnt;
  logic [c_cnt_w-1:0]   w_clk_cnt_nxt;
  logic [2:0]           r_idx;
  logic [2:0]           w_idx_nxt;
  logic [7:0]           r_sr;
  logic [7:0]           w_sr_nxt;
  logic                 r_tx;
  logic                 w_tx_nxt;
  logic                 r_busy;
  logic                 w_busy_nxt;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 w_bit_end;
  logic                 w_par_bit;

  assign w_bit_end = (r_clk_cnt == c_bit_last);

`ifdef TX_PARITY_EN
  logic r_par;

  // Even parity of the byte is captured at accept, since the shift
  // register no longer holds the byte by the time the parity slot starts.
  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      r_par <= 1'b0;
    end else if (r_state == ST_IDLE && iSTART) begin
      r_par <= ^iDATA;
    end
  end

  assign w_par_bit = r_par;
`else
  // Parity slot is plain mark on this link.
  assign w_par_bit = 1'b1;
`endif

  // State and datapath registers; reset forces the line back to mark at once.
  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      r_state   <= ST_IDLE;
      r_clk_cnt <= '0;
      r_idx     <= 3'd0;
      r_sr      <= 8'd0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_sr      <= w_sr_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Next-state and next-output logic; the line value is computed one clock
  // ahead so oTX comes straight from a flop.
  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = r_clk_cnt;
    w_idx_nxt     = r_idx;
    w_sr_nxt      = r_sr;
    w_tx_nxt      = r_tx;
    w_done_nxt    = 1'b0;

    if (r_state == ST_IDLE) begin
      w_clk_cnt_nxt = '0;
      w_idx_nxt     = 3'd0;
      w_tx_nxt      = 1'b1;
    end else begin
      w_clk_cnt_nxt = w_bit_end ? '0 : r_clk_cnt + 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        if (iSTART) begin
          w_state_nxt = ST_START;
          w_sr_nxt    = iDATA;
          w_tx_nxt    = 1'b0;
        end
      end

      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt = ST_DATA;
          w_tx_nxt    = r_sr[0];
          w_sr_nxt    = r_sr >> 1;
          w_idx_nxt   = 3'd0;
        end
      end

      ST_DATA: begin
        if (w_bit_end) begin
          if (r_idx == 3'd7) begin
            w_state_nxt = ST_PAR;
            w_tx_nxt    = w_par_bit;
          end else begin
            w_tx_nxt  = r_sr[0];
            w_sr_nxt  = r_sr >> 1;
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end

      ST_PAR: begin
        if (w_bit_end) begin
          w_state_nxt = ST_STOP;
          w_tx_nxt    = 1'b1;
        end
      end

      ST_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_bit_end) begin
          if (IDLE_BITS == 0) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_GAP;
            w_idx_nxt   = 3'd0;
          end
        end
      end

      ST_GAP: begin
        w_tx_nxt = 1'b1;
        if (w_bit_end) begin
          if (r_idx == c_gap_last) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign oTX   = r_tx;
  assign oBUSY = r_busy;
  assign oDONE = r_done;

endmodule

`default_nettype wire

// File: tb/tb_tx_rs232.sv
//==============================================================================
// Module      : tb_tx_rs232
// Description : Self-checking bench for tx_rs232 (CLK_PER_BIT=12,
//               IDLE_BITS=1). A frame-level model predicts the line on every
//               cycle; a mid-bit sampling receiver recovers bytes.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_tx_rs232;

  localparam int CPB   = 12;
  localparam int IDLE  = 1;
  localparam int TOTAL = (11 + IDLE) * CPB;

  logic       clk_s;
  logic       rstn_s;
  logic [7:0] iDATA;
  logic       iSTART;
  logic       oTX;
  logic       oBUSY;
  logic       oDONE;

  int errors = 0;
  int checks = 0;

  // Model state: clocks since the accept edge (-1 when idle) and the byte.
  int         m_age  = -1;
  logic       m_done = 1'b0;
  logic [7:0] m_byte = 8'd0;
  logic [7:0] sent_q[$];
  logic [7:0] rx_hist[$];

  logic cap[TOTAL];

  tx_rs232 #(.CLK_PER_BIT(CPB), .IDLE_BITS(IDLE)) dut (
    .clk_s (clk_s),
    .rstn_s(rstn_s),
    .iDATA (iDATA),
    .iSTART(iSTART),
    .oTX   (oTX),
    .oBUSY (oBUSY),
    .oDONE (oDONE)
  );

  initial begin
    clk_s = 1'b0;
    forever #5 clk_s = ~clk_s;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_par(input logic [7:0] b);
`ifdef TX_PARITY_EN
    return ^b;
`else
    return (^b) | 1'b1;
`endif
  endfunction

  // Line value at a given age: bit slot = age / CPB.
  function automatic logic exp_tx(input int age, input logic [7:0] b);
    int s;
    if (age < 0) return 1'b1;
    s = age / CPB;
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
    if (s == 9) return exp_par(b);
    return 1'b1;
  endfunction

  // Frame-level model: accept when idle and requested, finish after TOTAL clocks.
  initial begin
    forever begin
      @(posedge clk_s or negedge rstn_s);
      if (!rstn_s) begin
        m_age  = -1;
        m_done = 1'b0;
        sent_q.delete();
      end else if (m_age < 0) begin
        m_done = 1'b0;
        if (iSTART) begin
          m_age  = 0;
          m_byte = iDATA;
          sent_q.push_back(iDATA);
        end
      end else if (m_age == TOTAL - 1) begin
        m_age  = -1;
        m_done = 1'b1;
      end else begin
        m_age++;
      end
    end
  end

  // Per-cycle compare of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk_s);
      chk("cycle {tx,busy,done}", {29'd0, oTX, oBUSY, oDONE},
          {29'd0, exp_tx(m_age, m_byte), (m_age >= 0), m_done});
    end
  end

  // Mid-bit sampling receiver; checks recovered byte, parity slot and stop.
  initial begin
    int         rx_c;
    logic       rx_act;
    logic [7:0] rx_b;
    logic [7:0] want;
    rx_act = 1'b0;
    rx_c   = 0;
    rx_b   = 8'd0;
    forever begin
      @(negedge clk_s);
      if (!rstn_s) begin
        rx_act = 1'b0;
      end else if (!rx_act) begin
        if (oTX == 1'b0) begin
          rx_act = 1'b1;
          rx_c   = 0;
        end
      end else begin
        rx_c++;
        if (rx_c % CPB == CPB / 2) begin
          if (rx_c / CPB >= 1 && rx_c / CPB <= 8) rx_b[rx_c/CPB-1] = oTX;
          if (rx_c / CPB == 9) chk("rx parity slot", {31'd0, oTX}, {31'd0, exp_par(rx_b)});
          if (rx_c / CPB == 10) begin
            chk("rx stop bit", {31'd0, oTX}, 32'd1);
            rx_hist.push_back(rx_b);
            if (sent_q.size() == 0) begin
              chk("rx unexpected byte", {24'd0, rx_b}, 32'hFFFF_FFFF);
            end else begin
              want = sent_q.pop_front();
              chk("rx byte", {24'd0, rx_b}, {24'd0, want});
            end
            rx_act = 1'b0;
          end
        end
      end
    end
  end

  // Request one frame, capture the line per cycle, return clocks to oDONE.
  task automatic run_frame(input logic [7:0] d, output int n);
    iDATA  = d;
    iSTART = 1'b1;
    @(posedge clk_s); #1;
    iSTART = 1'b0;
    n = 0;
    while (!oDONE && n < 400) begin
      if (n < TOTAL) cap[n] = oTX;
      @(posedge clk_s); #1;
      n++;
    end
  endtask

  initial begin
    int n;
    int dones;
    int done_at;
    int lit_a5[12];
    lit_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 1};

    rstn_s = 1'b0;
    iSTART = 1'b0;
    iDATA  = 8'd0;
    repeat (3) @(posedge clk_s);
    #1;
    chk("reset oTX", {31'd0, oTX}, 32'd1);
    chk("reset oBUSY", {31'd0, oBUSY}, 32'd0);
    chk("reset oDONE", {31'd0, oDONE}, 32'd0);
    rstn_s = 1'b1;
    repeat (2) @(posedge clk_s);
    #1;

    // A5 frame against hand-written bit pattern and latency.
    run_frame(8'hA5, n);
    chk("a5 done latency", n, 32'd144);
    for (int k = 0; k < 12; k++) chk("a5 mid-bit", {31'd0, cap[k*CPB+CPB/2]}, lit_a5[k]);
    @(posedge clk_s); #1;
    chk("a5 done one cycle", {31'd0, oDONE}, 32'd0);

    // Loopback-style bytes.
    run_frame(8'h3C, n);
    chk("3c done latency", n, 32'd144);
    run_frame(8'h00, n);
    run_frame(8'hFF, n);
    repeat (3) @(posedge clk_s); #1;
    chk("loopback last byte", {24'd0, rx_hist[$]}, 32'h0000_00FF);

    // Busy protect: a request mid-frame is dropped.
    iDATA = 8'h55; iSTART = 1'b1;
    @(posedge clk_s); #1;
    iSTART = 1'b0;
    dones = 0; done_at = -1;
    for (int c = 0; c < 320; c++) begin
      if (c == 30) begin iSTART = 1'b1; iDATA = 8'h11; end
      if (c == 31) iSTART = 1'b0;
      if (oDONE) begin dones++; done_at = c; end
      @(posedge clk_s); #1;
    end
    chk("busy protect done count", dones, 32'd1);
    chk("busy protect done time", done_at, 32'd144);
    chk("busy protect rx byte", {24'd0, rx_hist[$]}, 32'h0000_0055);
    chk("busy protect idle", {31'd0, oBUSY}, 32'd0);

    // Reset 40 clocks into a frame.
    iDATA = 8'hC3; iSTART = 1'b1;
    @(posedge clk_s); #1;
    iSTART = 1'b0;
    repeat (40) @(posedge clk_s);
    #3;
    rstn_s = 1'b0;
    #1;
    chk("mid-frame reset oTX", {31'd0, oTX}, 32'd1);
    chk("mid-frame reset oBUSY", {31'd0, oBUSY}, 32'd0);
    repeat (2) @(posedge clk_s);
    #1;
    rstn_s = 1'b1;
    repeat (2) @(posedge clk_s); #1;

    // Back-to-back with iSTART held; iDATA change while busy has no effect.
    iDATA = 8'h81; iSTART = 1'b1;
    @(posedge clk_s); #1;
    iDATA = 8'h7E;
    n = 0;
    while (!oDONE && n < 400) begin @(posedge clk_s); #1; n++; end
    chk("b2b first done", n, 32'd144);
    @(posedge clk_s); #1;
    iSTART = 1'b0;
    chk("b2b second start oTX", {31'd0, oTX}, 32'd0);
    chk("b2b second start oBUSY", {31'd0, oBUSY}, 32'd1);
    n = 0;
    while (!oDONE && n < 400) begin @(posedge clk_s); #1; n++; end
    chk("b2b second done", n, 32'd144);
    repeat (3) @(posedge clk_s); #1;
    chk("b2b rx first", {24'd0, rx_hist[rx_hist.size()-2]}, 32'h0000_0081);
    chk("b2b rx second", {24'd0, rx_hist[rx_hist.size()-1]}, 32'h0000_007E);

    // Parity slot.
    run_frame(8'h07, n);
    chk("par 07", {31'd0, cap[9*CPB+CPB/2]}, 32'd1);
    run_frame(8'h03, n);
`ifdef TX_PARITY_EN
    chk("par 03", {31'd0, cap[9*CPB+CPB/2]}, 32'd0);
`else
    chk("par 03", {31'd0, cap[9*CPB+CPB/2]}, 32'd1);
`endif

    // Random requests and data, including changes while busy.
    for (int c = 0; c < 3000; c++) begin
      iSTART = ($urandom_range(0, 7) == 0);
      iDATA  = 8'($urandom);
      @(posedge clk_s); #1;
    end
    iSTART = 1'b0;
    repeat (200) @(posedge clk_s); #1;
    chk("all sent bytes received", sent_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
